// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared opcodes, ALU selects, FSM states and field widths for control_circuit_param
package cc_pkg;

    localparam int OPC_W  = 4;
    localparam int RFLD_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_LOADL = 4'd2;
    localparam logic [OPC_W-1:0] OP_MOV   = 4'd3;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd4;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'd5;
    localparam logic [OPC_W-1:0] OP_AND   = 4'd6;
    localparam logic [OPC_W-1:0] OP_OR    = 4'd7;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } cc_state_t;

endpackage

// File: rtl/cc_onehot_dec.sv
// rtl/cc_onehot_dec.sv - register index to one-hot enable decoder, zero when disabled or out of range
module cc_onehot_dec
    import cc_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic [RFLD_W-1:0]   idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // an index past the last register matches no bit, so the output stays zero
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (idx == RFLD_W'(i));
        end
    end

endmodule

// File: rtl/control_circuit_param.sv
// rtl/control_circuit_param.sv - instruction sequencer for the shared-bus datapath; CC_BACK_TO_BACK_EN allows accept in the done step
module control_circuit_param
    import cc_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int INSTR_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic                ext_data_en,
    output logic                ext_data_low_reg_en,
    output logic [NUM_REGS-1:0] reg_in_en,
    output logic [NUM_REGS-1:0] reg_out_en,
    output logic                alu_reg_en,
    output logic [1:0]          alu_sel,
    output logic                alu_out_en,
    output logic                g_reg_en,
    output logic                done,
    output logic                illegal
);

    cc_state_t         state, state_nxt;
    logic [OPC_W-1:0]  opc_q;
    logic [RFLD_W-1:0] rx_q, ry_q;

    logic              accept;
    logic              is_alu, uses_rx, uses_ry, rx_ok, ry_ok, bad_instr;
    logic              in_en, out_en, out_sel_ry, final_step;
    logic [RFLD_W-1:0] out_idx;
    logic              unused_instr_bits;

    // low instruction bits carry no meaning for this block
    assign unused_instr_bits = ^instr;

    assign accept = instr_valid && instr_ready;

    // legality depends only on the latched fields, never on the live instr bus
    always_comb begin
        is_alu    = (opc_q[3:2] == 2'b01);
        uses_rx   = !opc_q[3] && (opc_q != OP_NOP);
        uses_ry   = (opc_q == OP_MOV) || is_alu;
        rx_ok     = ({{(32-RFLD_W){1'b0}}, rx_q} < NUM_REGS);
        ry_ok     = ({{(32-RFLD_W){1'b0}}, ry_q} < NUM_REGS);
        bad_instr = opc_q[3] || (uses_rx && !rx_ok) || (uses_ry && !ry_ok);
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // instruction field capture on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            opc_q <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
        end else if (accept) begin
            opc_q <= instr[INSTR_W-1 -: OPC_W];
            rx_q  <= instr[INSTR_W-5 -: RFLD_W];
            ry_q  <= instr[INSTR_W-9 -: RFLD_W];
        end
    end

    // next-state and step outputs decoded from state and latched fields
    always_comb begin
        state_nxt           = state;
        instr_ready         = 1'b0;
        ext_data_en         = 1'b0;
        ext_data_low_reg_en = 1'b0;
        alu_reg_en          = 1'b0;
        alu_sel             = ALU_ADD;
        alu_out_en          = 1'b0;
        g_reg_en            = 1'b0;
        done                = 1'b0;
        illegal             = 1'b0;
        in_en               = 1'b0;
        out_en              = 1'b0;
        out_sel_ry          = 1'b0;
        final_step          = 1'b0;

        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = ST_T1;
            end
            ST_T1: begin
                if (bad_instr) begin
                    done       = 1'b1;
                    illegal    = 1'b1;
                    final_step = 1'b1;
                end else begin
                    case (opc_q)
                        OP_NOP: begin
                            done       = 1'b1;
                            final_step = 1'b1;
                        end
                        OP_LOAD: begin
                            ext_data_en = 1'b1;
                            in_en       = 1'b1;
                            done        = 1'b1;
                            final_step  = 1'b1;
                        end
                        OP_LOADL: begin
                            ext_data_low_reg_en = 1'b1;
                            in_en               = 1'b1;
                            done                = 1'b1;
                            final_step          = 1'b1;
                        end
                        OP_MOV: begin
                            out_en     = 1'b1;
                            out_sel_ry = 1'b1;
                            in_en      = 1'b1;
                            done       = 1'b1;
                            final_step = 1'b1;
                        end
                        default: begin
                            out_en     = 1'b1;
                            alu_reg_en = 1'b1;
                            state_nxt  = ST_T2;
                        end
                    endcase
                end
            end
            ST_T2: begin
                out_en     = 1'b1;
                out_sel_ry = 1'b1;
                alu_sel    = opc_q[1:0];
                g_reg_en   = 1'b1;
                state_nxt  = ST_T3;
            end
            ST_T3: begin
                alu_out_en = 1'b1;
                in_en      = 1'b1;
                done       = 1'b1;
                final_step = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (final_step) begin
            state_nxt = ST_IDLE;
`ifdef CC_BACK_TO_BACK_EN
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = ST_T1;
`endif
        end
    end

    assign out_idx = out_sel_ry ? ry_q : rx_q;

    cc_onehot_dec #(.NUM_REGS(NUM_REGS)) u_in_dec (
        .idx    (rx_q),
        .en     (in_en),
        .onehot (reg_in_en)
    );

    cc_onehot_dec #(.NUM_REGS(NUM_REGS)) u_out_dec (
        .idx    (out_idx),
        .en     (out_en),
        .onehot (reg_out_en)
    );

endmodule
